// File: rtl/pi1_rrarb_pkg.sv
// Shared encodings for the PI1 round-robin arbiter: bus op codes and FSM states.
package pi1_rrarb_pkg;

  localparam int OPW = 2;

  typedef enum logic [OPW-1:0] {
    NOOP = 2'd0,
    WROP = 2'd1,
    RDOP = 2'd2,
    RWOP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

endpackage

// File: rtl/pi1_rrarb_pick.sv
// Combinational round-robin winner search: starts one past the last owner and
// returns the first requester as a one-hot grant, so the last owner ranks lowest.
module pi1_rrarb_pick #(
  parameter int MCOUNT = 2,
  localparam int IDXW = $clog2(MCOUNT)
) (
  input  logic [MCOUNT-1:0] req,
  input  logic [IDXW-1:0]   last,
  output logic [MCOUNT-1:0] gnt,
  output logic              vld
);

  // Walk offsets 1..MCOUNT from the last owner; the first requester found wins.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int i = 1; i <= MCOUNT; i++) begin
      for (int j = 0; j < MCOUNT; j++) begin
        if (!vld && req[j] && (j == ((int'(last) + i) % MCOUNT))) begin
          gnt[j] = 1'b1;
          vld    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pi1_rrarb.sv
// PI1 round-robin arbiter: shares one slave among MCOUNT masters using a
// two-phase (request, response) handshake with back-to-back grants.
module pi1_rrarb
  import pi1_rrarb_pkg::*;
#(
  parameter int MCOUNT    = 2,
  parameter int ARCHBITSZ = 32,
  localparam int SELW      = ARCHBITSZ / 8,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(SELW),
  localparam int IDXW      = $clog2(MCOUNT)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [OPW*MCOUNT-1:0]       m_op_i,
  input  logic [ADDRBITSZ*MCOUNT-1:0] m_addr_i,
  input  logic [ARCHBITSZ*MCOUNT-1:0] m_data_i,
  input  logic [SELW*MCOUNT-1:0]      m_sel_i,
  output logic [ARCHBITSZ-1:0]        m_data_o,
  output logic [MCOUNT-1:0]           m_rdy_o,
  output logic [OPW-1:0]              s_op_o,
  output logic [ADDRBITSZ-1:0]        s_addr_o,
  output logic [ARCHBITSZ-1:0]        s_data_o,
  output logic [SELW-1:0]             s_sel_o,
  input  logic [ARCHBITSZ-1:0]        s_data_i,
  input  logic                        s_rdy_i,
  output logic [MCOUNT-1:0]           gnt_o
);

  state_e                 state_q, state_d;
  logic [MCOUNT-1:0]      gnt_q, gnt_d;
  logic [IDXW-1:0]        own_q, own_d;
  logic [IDXW-1:0]        last_q, last_d;

  logic [MCOUNT-1:0]      req_vec;
  logic [MCOUNT-1:0]      pick_req;
  logic [MCOUNT-1:0]      pick_gnt;
  logic                   pick_vld;
  logic [IDXW-1:0]        pick_last;
  logic [IDXW-1:0]        pick_idx;

  logic [OPW-1:0]         own_op;
  logic [ADDRBITSZ-1:0]   own_addr;
  logic [ARCHBITSZ-1:0]   own_data;
  logic [SELW-1:0]        own_sel;

  // A master is requesting whenever its op is anything but NOOP.
  always_comb begin
    req_vec = '0;
    for (int i = 0; i < MCOUNT; i++) begin
      req_vec[i] = (m_op_i[OPW*i +: OPW] != NOOP);
    end
  end

  // AND-OR mux of the owner's fields; collapses to zero when nobody owns the bus.
  always_comb begin
    own_op   = '0;
    own_addr = '0;
    own_data = '0;
    own_sel  = '0;
    for (int i = 0; i < MCOUNT; i++) begin
      if (gnt_q[i]) begin
        own_op   = m_op_i[OPW*i +: OPW];
        own_addr = m_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
        own_data = m_data_i[ARCHBITSZ*i +: ARCHBITSZ];
        own_sel  = m_sel_i[SELW*i +: SELW];
      end
    end
  end

  // At the end of a response the current owner becomes the lowest-priority
  // master and is excluded, so a hand-over only happens to a different master.
  assign pick_req  = req_vec & ~gnt_q;
  assign pick_last = (state_q == RSP) ? own_q : last_q;

  pi1_rrarb_pick #(
    .MCOUNT (MCOUNT)
  ) u_pick (
    .req  (pick_req),
    .last (pick_last),
    .gnt  (pick_gnt),
    .vld  (pick_vld)
  );

  // One-hot winner to index, kept alongside the grant for the last-owner record.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < MCOUNT; i++) begin
      if (pick_gnt[i]) pick_idx = IDXW'(i);
    end
  end

  // Next-state logic: arbitrate in IDLE, forward in REQ, wait for the response in RSP.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = REQ;
          gnt_d   = pick_gnt;
          own_d   = pick_idx;
        end
      end
      REQ: begin
        if (own_op == NOOP) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = own_q;
        end else if (s_rdy_i) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (s_rdy_i) begin
          last_d = own_q;
          if (pick_vld) begin
            state_d = REQ;
            gnt_d   = pick_gnt;
            own_d   = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State register; reset makes master 0 the first winner.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      last_q  <= IDXW'(MCOUNT - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
    end
  end

  // Slave-side request and per-master ready; only REQ forwards an op.
  always_comb begin
    s_op_o   = (state_q == REQ) ? own_op : NOOP;
    s_addr_o = own_addr;
    s_data_o = own_data;
    s_sel_o  = own_sel;
    m_rdy_o  = '0;
    if (state_q == REQ || state_q == RSP) begin
      m_rdy_o = gnt_q & {MCOUNT{s_rdy_i}};
    end
  end

  assign m_data_o = s_data_i;
  assign gnt_o    = gnt_q;

endmodule

// File: doc/pi1_rrarb.md
PI1_RRARB -- requirements
Module: pi1_rrarb

Interface
REQ-001 Parameter: MCOUNT, 2, number of masters sharing the slave, legal range 2..16.
REQ-002 Parameter: ARCHBITSZ, 32, data width; ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8), local.
REQ-003 Port: clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst_i  in  1  reset, asynchronous, active-low.
REQ-005 Port: m_op_i  in  2*MCOUNT  per-master op, master i at bits [2i+1:2i].
REQ-006 Port: m_addr_i  in  ADDRBITSZ*MCOUNT  per-master word address.
REQ-007 Port: m_data_i  in  ARCHBITSZ*MCOUNT  per-master write data.
REQ-008 Port: m_sel_i  in  (ARCHBITSZ/8)*MCOUNT  per-master byte select.
REQ-009 Port: m_data_o  out  ARCHBITSZ  slave read data broadcast to all masters.
REQ-010 Port: m_rdy_o  out  MCOUNT  per-master ready.
REQ-011 Port: s_op_o, s_addr_o, s_data_o, s_sel_o  out  2/ADDRBITSZ/ARCHBITSZ/ARCHBITSZ/8  slave request.
REQ-012 Port: s_data_i  in  ARCHBITSZ; s_rdy_i  in  1  slave read data and ready.
REQ-013 Port: gnt_o  out  MCOUNT  one-hot current owner, all-zero when none.

Function
REQ-014 Op encoding SHALL be NOOP=0, WROP=1, RDOP=2, RWOP=3.
REQ-015 Each transaction SHALL have two phases: request accepted on a cycle with op!=NOOP and rdy=1, then a response on the next cycle with rdy=1.
REQ-016 The response cycle SHALL NOT accept a new op; a master holds its op until accepted.
REQ-017 States SHALL be IDLE, REQ and RSP.
REQ-018 IDLE: s_op_o=NOOP, m_rdy_o=0; if any m_op!=NOOP, register the winner in gnt_o and go to REQ next cycle (1-cycle arbitration latency).
REQ-019 Winner selection SHALL be round-robin: search starts at index (last owner + 1) mod MCOUNT and takes the first requester, so the last owner has lowest priority.
REQ-020 REQ: the owner's op, addr, data and sel SHALL drive s_*; m_rdy_o[owner]=s_rdy_i; other m_rdy_o bits are 0.
REQ-021 REQ and s_rdy_i=1 with owner op!=NOOP: go to RSP.
REQ-022 REQ with owner op=NOOP (request withdrawn): return to IDLE and record the owner as last owner.
REQ-023 RSP: s_op_o=NOOP; m_rdy_o[owner]=s_rdy_i; stay while s_rdy_i=0.
REQ-024 RSP with s_rdy_i=1: record the owner as last owner.
  - If another master is requesting, go directly to REQ with the new winner; no IDLE bubble.
  - Otherwise go to IDLE; the owner's own pending op is treated as a new request from IDLE.
REQ-025 m_data_o SHALL equal s_data_i combinationally in all states.
REQ-026 s_addr_o, s_data_o and s_sel_o SHALL be zero when gnt_o is zero.
REQ-027 A change in non-owner inputs SHALL NOT affect s_* outputs or state.
REQ-028 WROP, RDOP and RWOP SHALL be sequenced identically; RWOP is one atomic transaction.

Reset
REQ-029 On rst_i low, asynchronously: state=IDLE, gnt_o=0, last owner=MCOUNT-1 (master 0 wins first), s_op_o=NOOP, m_rdy_o=0.
REQ-030 Reset asserted mid-transaction SHALL abandon it silently; no response is delivered after release.
REQ-031 The first arbitration SHALL occur on the first rising edge with rst_i high.

Structure
REQ-032 A shared package SHALL hold the op encodings (NOOP/WROP/RDOP/RWOP) and the state encodings (IDLE/REQ/RSP).
REQ-033 The round-robin winner search SHALL be a sub-module pi1_rrarb_pick.
  - Inputs: request vector and last-owner index.
  - Outputs: one-hot grant and a valid flag.
  - It is combinational; all registers stay in pi1_rrarb.

Verification
REQ-034 Reset release, master 0 RDOP addr 0x10, slave s_rdy_i=1 -> gnt_o=01 one cycle later; request accepted in REQ; data on m_data_o with m_rdy_o[0]=1 in RSP.
REQ-035 MCOUNT=4, masters 0-3 all continuously WROP -> grants follow order 0,1,2,3,0, with REQ immediately after each RSP (no IDLE cycle).
REQ-036 Owner in RSP, s_rdy_i held low 5 cycles -> state holds RSP, m_rdy_o=0 for all, s_op_o=NOOP; completes on the 6th cycle.
REQ-037 Master 1 withdraws to NOOP while in REQ with s_rdy_i=0 -> IDLE next cycle; a subsequent request from master 1 alone is granted.
REQ-038 rst_i pulled low during RSP -> gnt_o=0 and m_rdy_o=0 immediately; after release, master 0 wins a simultaneous master 0/1 request.
REQ-039 Master 2 RWOP with sel=0xF, data 0xDEADBEEF -> s_* carry exactly the master 2 fields; masters 0, 1 and 3 see m_rdy_o=0 throughout.
